// File: rtl/arbitro_carga_reg4b.sv
// Round-robin arbiter and load sequencer for one shared 4-bit register.
// Four requesters compete. The winner's word goes into the shared register,
// and the block then completes a four-phase req/ack handshake with it.
// A wrapping load counter is kept for debug visibility.
module arbitro_carga_reg4b #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       reloj,
    input  logic                       despeje_reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     datos,
    output logic [WIDTH-1:0]           An,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       ocupado,
    output logic                       valido,
    output logic [CNT_W-1:0]           cuenta_cargas
);

    localparam int unsigned ID_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        StLibre    = 2'd0,
        StConcede  = 2'd1,
        StCargaAck = 2'd2
    } estado_e;

    estado_e           state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0]  an_q, an_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic              valido_q, valido_d;
    logic [CNT_W-1:0]  cuenta_q, cuenta_d;

    logic [WIDTH-1:0]  palabra [N_REQ];
    logic [ID_W-1:0]   sel_id;
    logic              sel_hit;
    logic [ID_W-1:0]   idx;

    // Split the flat data bus into one word per requester.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            palabra[i] = datos[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin search: first set request starting at ptr and wrapping around.
    // N_REQ is a power of two, so the ID_W-bit add wraps modulo N_REQ by itself.
    always_comb begin
        sel_id  = '0;
        sel_hit = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr_q + ID_W'(k);
            if (!sel_hit && req[idx]) begin
                sel_hit = 1'b1;
                sel_id  = idx;
            end
        end
    end

    // Next-state and datapath update for the grant/load/handshake sequence.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_id_d = gnt_id_q;
        an_d     = an_q;
        ack_d    = ack_q;
        valido_d = 1'b0;
        cuenta_d = cuenta_q;

        unique case (state_q)
            StLibre: begin
                if (sel_hit) begin
                    gnt_id_d = sel_id;
                    state_d  = StConcede;
                end
            end

            StConcede: begin
                if (req[gnt_id_q]) begin
                    an_d            = palabra[gnt_id_q];
                    ack_d           = '0;
                    ack_d[gnt_id_q] = 1'b1;
                    valido_d        = 1'b1;
                    cuenta_d        = cuenta_q + 1'b1;
                    state_d         = StCargaAck;
                end else begin
                    // Withdrawn before the load: no side effects, pointer kept.
                    state_d = StLibre;
                end
            end

            StCargaAck: begin
                // Wait for the granted requester to drop req; ignore everything else.
                if (!req[gnt_id_q]) begin
                    ack_d   = '0;
                    ptr_d   = gnt_id_q + 1'b1;
                    state_d = StLibre;
                end
            end

            default: begin
                state_d = StLibre;
                ack_d   = '0;
            end
        endcase
    end

    // State and datapath registers; the asynchronous reset aborts any transaction.
    always_ff @(posedge reloj or posedge despeje_reset) begin
        if (despeje_reset) begin
            state_q  <= StLibre;
            ptr_q    <= '0;
            gnt_id_q <= '0;
            an_q     <= '0;
            ack_q    <= '0;
            valido_q <= 1'b0;
            cuenta_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_id_q <= gnt_id_d;
            an_q     <= an_d;
            ack_q    <= ack_d;
            valido_q <= valido_d;
            cuenta_q <= cuenta_d;
        end
    end

    // Outputs come straight from the registers; ocupado decodes the state.
    always_comb begin
        An            = an_q;
        ack           = ack_q;
        gnt_id        = gnt_id_q;
        valido        = valido_q;
        cuenta_cargas = cuenta_q;
        ocupado       = (state_q != StLibre);
    end

endmodule

// File: tb/tb_arbitro_carga_reg4b.sv
// Self-checking bench for arbitro_carga_reg4b with a transaction-level model.
module tb_arbitro_carga_reg4b;

    logic        reloj;
    logic        despeje_reset;
    logic [3:0]  req;
    logic [15:0] datos;
    logic [3:0]  An;
    logic [3:0]  ack;
    logic [1:0]  gnt_id;
    logic        ocupado;
    logic        valido;
    logic [7:0]  cuenta_cargas;

    int checks = 0;
    int errors = 0;

    // Reference model: rotating priority pointer, last loaded word, load count.
    int         exp_ptr = 0;
    logic [3:0] exp_an  = 4'h0;
    logic [7:0] exp_cnt = 8'h00;

    arbitro_carga_reg4b dut (
        .reloj         (reloj),
        .despeje_reset (despeje_reset),
        .req           (req),
        .datos         (datos),
        .An            (An),
        .ack           (ack),
        .gnt_id        (gnt_id),
        .ocupado       (ocupado),
        .valido        (valido),
        .cuenta_cargas (cuenta_cargas)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    // Called 1 time unit after a rising edge; asserts reset mid-cycle.
    task automatic apply_reset();
        #2;
        despeje_reset = 1'b1;
        #1;
        checks++;
        if (An !== 4'h0 || ack !== 4'h0 || gnt_id !== 2'd0 || ocupado !== 1'b0 ||
            valido !== 1'b0 || cuenta_cargas !== 8'h00) begin
            errors++;
            $display("FAIL reset: An=%h ack=%b gnt_id=%0d ocupado=%b valido=%b cnt=%h, expected all zero",
                     An, ack, gnt_id, ocupado, valido, cuenta_cargas);
        end
        req = 4'b0000;
        #1;
        despeje_reset = 1'b0;
        exp_ptr = 0;
        exp_an  = 4'h0;
        exp_cnt = 8'h00;
        step();
        checks++;
        if (ocupado !== 1'b0 || ack !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle: ocupado=%b ack=%b, expected 0 and 0000", ocupado, ack);
        end
    endtask

    // One full transaction: raise rv, expect grant, load, hold, release.
    task automatic do_load(input logic [3:0] rv, input logic [15:0] dv);
        int         g;
        logic [3:0] w;
        logic [3:0] oh;
        req   = rv;
        datos = dv;
        g     = rr_pick(rv, exp_ptr);
        w     = 4'((dv >> (4 * g)) & 16'h000F);
        oh    = 4'(1 << g);
        step();
        checks++;
        if (gnt_id !== 2'(g) || ocupado !== 1'b1 || ack !== 4'h0 || valido !== 1'b0) begin
            errors++;
            $display("FAIL grant: gnt_id=%0d ocupado=%b ack=%b valido=%b, expected %0d 1 0000 0",
                     gnt_id, ocupado, ack, valido, g);
        end
        step();
        exp_an  = w;
        exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (An !== exp_an || ack !== oh || valido !== 1'b1 || cuenta_cargas !== exp_cnt) begin
            errors++;
            $display("FAIL load: An=%h ack=%b valido=%b cnt=%h, expected %h %b 1 %h",
                     An, ack, valido, cuenta_cargas, exp_an, oh, exp_cnt);
        end
        datos = 16'($urandom);
        step();
        checks++;
        if (An !== exp_an || ack !== oh || valido !== 1'b0 || ocupado !== 1'b1) begin
            errors++;
            $display("FAIL hold: An=%h ack=%b valido=%b ocupado=%b, expected %h %b 0 1",
                     An, ack, valido, ocupado, exp_an, oh);
        end
        req[g] = 1'b0;
        step();
        exp_ptr = (g + 1) % 4;
        checks++;
        if (ack !== 4'h0 || ocupado !== 1'b0 || An !== exp_an || cuenta_cargas !== exp_cnt) begin
            errors++;
            $display("FAIL release: ack=%b ocupado=%b An=%h cnt=%h, expected 0000 0 %h %h",
                     ack, ocupado, An, cuenta_cargas, exp_an, exp_cnt);
        end
    endtask

    task automatic test_reset();
        req   = 4'b0001;
        datos = 16'h000A;
        step();
        step();
        checks++;
        if (An !== 4'hA || ack !== 4'b0001) begin
            errors++;
            $display("FAIL reset_pre: An=%h ack=%b, expected a 0001", An, ack);
        end
        apply_reset();
    endtask

    task automatic test_single();
        do_load(4'b0001, 16'h0009);
        checks++;
        if (cuenta_cargas !== 8'd1) begin
            errors++;
            $display("FAIL single_count: cnt=%h, expected 01", cuenta_cargas);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] seen [5];
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            do_load(4'b1111, 16'h4321);
            seen[n] = An;
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (seen[n] !== 4'((n % 4) + 1)) begin
                errors++;
                $display("FAIL rr_order[%0d]: An=%h, expected %h", n, seen[n], (n % 4) + 1);
            end
        end
    endtask

    task automatic test_priority();
        apply_reset();
        do_load(4'b0100, 16'h0700);
        req   = 4'b0101;
        datos = 16'h0B0C;
        step();
        checks++;
        if (gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL priority: gnt_id=%0d, expected 0", gnt_id);
        end
        req = 4'b0000;
        step();
        exp_ptr = 3;
    endtask

    task automatic test_withdraw();
        do_load(4'b0010, 16'h00D0);
        req = 4'b0100;
        step();
        req = 4'b0000;
        step();
        checks++;
        if (ack !== 4'h0 || An !== exp_an || cuenta_cargas !== exp_cnt || ocupado !== 1'b0 ||
            valido !== 1'b0) begin
            errors++;
            $display("FAIL withdraw: ack=%b An=%h cnt=%h ocupado=%b valido=%b, expected 0000 %h %h 0 0",
                     ack, An, cuenta_cargas, ocupado, valido, exp_an, exp_cnt);
        end
        // Pointer must be unchanged: with all requesting, requester 2 wins next.
        do_load(4'b1111, 16'h5678);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            do_load(4'($urandom_range(1, 15)), 16'($urandom));
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            do_load(4'($urandom_range(1, 15)), 16'($urandom));
        end
        checks++;
        if (cuenta_cargas !== 8'h00 || An !== exp_an) begin
            errors++;
            $display("FAIL wrap: cnt=%h An=%h, expected 00 %h", cuenta_cargas, An, exp_an);
        end
    endtask

    initial begin
        despeje_reset = 1'b0;
        req           = 4'b0000;
        datos         = 16'h0000;
        apply_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_priority();
        test_withdraw();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
